nes_joypad_port: RTL
====================

// Module: nes_joypad_port
// PURPOSE
//  Responder side of the 2A03 controller interface: emulates two standard NES pads (4021-style shift regs).
//  Consumes CPU strobes addr4016w/naddr4016r/naddr4017r; returns serial button bits on the CPU read bus.
//  Sits between cpu_2a03 and the board's button inputs; the system bus mux selects joy_data when joy_oe=1.
// PARAMETERS
//  SYNC_STAGES        2      flops in each button-input synchronizer (min 2)
//  TURBO_HALF_PERIOD  59659  clocks per turbo toggle half-period (~15 Hz at 1.79 MHz); used only with macro
// PORTS
//  clock        in   1  system clock (CPU clock domain); the block's one clock
//  reset        in   1  synchronous, active-high reset
//  addr4016w    in   3  OUT2..OUT0 latch from $4016 write; bit0 = controller strobe
//  naddr4016r   in   1  active-low: CPU reading $4016 (pad 1)
//  naddr4017r   in   1  active-low: CPU reading $4017 (pad 2)
//  buttons_p1   in   8  raw pad-1 buttons, 1=pressed; bit0..7 = A,B,Select,Start,Up,Down,Left,Right
//  buttons_p2   in   8  raw pad-2 buttons, same order
//  joy_data     out  8  read data: {7'b0, serial bit} of the pad being read
//  joy_oe       out  1  1 while either read strobe is low
// BEHAVIOUR
//  - Reset: both shift regs 8'hFF, synchronizers cleared to 0, read-edge trackers = 1, joy_data=0, joy_oe=0.
//  - Buttons pass through SYNC_STAGES flops; shifter sees only synchronized values (SYNC_STAGES clocks latency).
//  - Strobe high (addr4016w[0]=1): every clock, shift reg <= synced buttons (pressed=1); serial bit = A.
//  - Strobe low: reg holds; a read access shifts once: on the clock where naddr401xr goes 0->1
//    (registered previous value low, current high), reg <= {1'b1, reg[7:1]}.
//  - One shift per access regardless of how many cycles the strobe is held low.
//  - Serial bit = reg[0]; after 8 shifts reg is all ones -> further reads return 1 (saturating, no wrap).
//  - joy_data combinational: naddr4016r=0 -> pad1 reg[0]; else naddr4017r=0 -> pad2 reg[0]; else 8'h00.
//    Both low simultaneously: pad 1 wins data; both pads still shift on their own rising edges.
//  - Strobe high and read end in the same clock: reload wins, no shift.
//  - Strobe 1->0: last reload value held; first read returns A.
//  - Reset mid-sequence: regs forced to FF; a read strobe low at reset release causes no shift
//    until it goes low->high after release (tracker starts at 1, so the first rising edge after a fresh low shifts).
//  - addr4016w[2:1] are ignored (expansion port; no function here).
// CONFIGURATION
//  Macro JOYPAD_TURBO_EN:
//   defined: extra inputs turbo_a_p1, turbo_b_p1, turbo_a_p2, turbo_b_p2 (1 bit each, synchronized like buttons).
//    Free-running counter 0..TURBO_HALF_PERIOD-1 toggles turbo_phase on wrap (reset: count 0, phase 0).
//    Effective A = synced A | (turbo_a & turbo_phase); B likewise. Used at strobe reload only.
//   undefined: turbo ports, counter and phase absent; effective buttons = synced buttons.
// STRUCTURE
//  - Shared include joypad_values.v: `define JOY_BTN_A 0 .. `JOY_BTN_RIGHT 7, `JOY_SHIFT_FILL 1'b1,
//    `JOY_IDLE_DATA 8'h00. cpu_2a03 bus mux uses the same include.
//  - Sub-module joypad_shifter (one per pad): clock, reset, strobe, nread, buttons[7:0] -> serial_bit;
//    contains the 8-bit reg and read-edge tracker. Top holds synchronizers, turbo timer, output mux.
// TESTING
//  1 Reset, no strobe; read $4016 x3 -> joy_data=8'h01 each time; joy_oe=1 only during read low.
//  2 buttons_p1=8'h09 (A,Start), strobe 1 then 0, 8 reads of $4016 -> bits 1,0,0,1,0,0,0,0; 9th,10th read -> 1.
//  3 buttons_p2=8'h80 (Right), strobe pulse; reads $4017 x8 -> 0x7 then 1; pad-1 state unchanged throughout.
//  4 Strobe held 1, read $4016 x4 while buttons_p1=8'h01 -> always 1 (no shift); buttons_p1->8'h00, wait
//    SYNC_STAGES+1 clocks, read -> 0.
//  5 naddr4016r held low 5 clocks, then high -> exactly one shift (next read returns B); assert reset
//    mid-sequence after 3 reads -> next read returns 1, no spurious shift after release.
//  6 JOYPAD_TURBO_EN, TURBO_HALF_PERIOD=4, turbo_a_p1=1, buttons 0: strobe reload at phase 1 -> first read 1;
//    at phase 0 -> 0; build without macro compiles and passes tests 1-5.

Source files
------------

// File: rtl/nes_joypad_port_pkg.sv
// Shared constants and helpers for the NES controller port responder.
// Button bit positions follow the 4021 shift order: A first out, Right last.
package nes_joypad_port_pkg;

  typedef enum logic [2:0] {
    JOY_BTN_A      = 3'd0,
    JOY_BTN_B      = 3'd1,
    JOY_BTN_SELECT = 3'd2,
    JOY_BTN_START  = 3'd3,
    JOY_BTN_UP     = 3'd4,
    JOY_BTN_DOWN   = 3'd5,
    JOY_BTN_LEFT   = 3'd6,
    JOY_BTN_RIGHT  = 3'd7
  } joy_btn_e;

  typedef logic [7:0] pad_buttons_t;

  localparam logic         JOY_SHIFT_FILL  = 1'b1;
  localparam logic [7:0]   JOY_IDLE_DATA   = 8'h00;
  localparam pad_buttons_t JOY_RESET_VALUE = 8'hFF;

  // OR the turbo modulation into A/B; other buttons pass through untouched.
  function automatic pad_buttons_t apply_turbo(input pad_buttons_t btn,
                                               input logic turbo_a,
                                               input logic turbo_b,
                                               input logic phase);
    pad_buttons_t eff;
    eff = btn;
    eff[JOY_BTN_A] = btn[JOY_BTN_A] | (turbo_a & phase);
    eff[JOY_BTN_B] = btn[JOY_BTN_B] | (turbo_b & phase);
    return eff;
  endfunction

endpackage

// File: rtl/joypad_shifter.sv
// One emulated 4021 pad: parallel reload while strobed, one right-shift per
// completed read access (detected on the read strobe's rising edge).
module joypad_shifter
  import nes_joypad_port_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         strobe,
  input  logic         nread,
  input  pad_buttons_t buttons,
  output logic         serial_bit
);

  pad_buttons_t shift_reg;
  logic         nread_q;
  logic         read_done;

  // Tracker resets high so a strobe already low at reset release needs a
  // fresh low sample before its rising edge counts.
  assign read_done = ~nread_q & nread;

  always_ff @(posedge clock) begin
    if (reset) begin
      shift_reg <= JOY_RESET_VALUE;
      nread_q   <= 1'b1;
    end else begin
      nread_q <= nread;
      if (strobe) begin
        shift_reg <= buttons;
      end else if (read_done) begin
        shift_reg <= {JOY_SHIFT_FILL, shift_reg[7:1]};
      end
    end
  end

  assign serial_bit = shift_reg[0];

endmodule

// File: rtl/nes_joypad_port.sv
// NES $4016/$4017 controller responder: button synchronizers, two pad shifters
// and the read-data mux. Optional turbo A/B behind macro JOYPAD_TURBO_EN.
module nes_joypad_port
  import nes_joypad_port_pkg::*;
#(
  parameter int SYNC_STAGES       = 2,
  parameter int TURBO_HALF_PERIOD = 59659
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] addr4016w,
  input  logic       naddr4016r,
  input  logic       naddr4017r,
  input  logic [7:0] buttons_p1,
  input  logic [7:0] buttons_p2,
`ifdef JOYPAD_TURBO_EN
  input  logic       turbo_a_p1,
  input  logic       turbo_b_p1,
  input  logic       turbo_a_p2,
  input  logic       turbo_b_p2,
`endif
  output logic [7:0] joy_data,
  output logic       joy_oe
);

  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

`ifdef JOYPAD_TURBO_EN
  localparam int SYNC_W = 20;
`else
  localparam int SYNC_W = 16;
`endif

  logic [SYNC_W-1:0]             sync_in;
  logic [STAGES-1:0][SYNC_W-1:0] sync_q;
  logic [SYNC_W-1:0]             sync_out;
  pad_buttons_t                  sync_p1;
  pad_buttons_t                  sync_p2;
  pad_buttons_t                  eff_p1;
  pad_buttons_t                  eff_p2;
  logic                          strobe;
  logic                          bit_p1;
  logic                          bit_p2;

  // Expansion-port latch bits have no function on a standard pad.
  logic       unused_expansion;
  logic [31:0] unused_turbo_cfg;
  assign unused_expansion = ^addr4016w[2:1];
  assign unused_turbo_cfg = 32'(TURBO_HALF_PERIOD);

  assign strobe = addr4016w[0];

`ifdef JOYPAD_TURBO_EN
  assign sync_in = {turbo_b_p2, turbo_a_p2, turbo_b_p1, turbo_a_p1, buttons_p2, buttons_p1};
`else
  assign sync_in = {buttons_p2, buttons_p1};
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= sync_in;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign sync_out = sync_q[STAGES-1];
  assign sync_p1  = sync_out[7:0];
  assign sync_p2  = sync_out[15:8];

`ifdef JOYPAD_TURBO_EN
  localparam int TURBO_CNT_W = (TURBO_HALF_PERIOD > 2) ? $clog2(TURBO_HALF_PERIOD) : 1;
  localparam logic [TURBO_CNT_W-1:0] TURBO_LAST = TURBO_CNT_W'(TURBO_HALF_PERIOD - 1);

  logic [TURBO_CNT_W-1:0] turbo_cnt;
  logic                   turbo_phase;

  always_ff @(posedge clock) begin
    if (reset) begin
      turbo_cnt   <= '0;
      turbo_phase <= 1'b0;
    end else if (turbo_cnt == TURBO_LAST) begin
      turbo_cnt   <= '0;
      turbo_phase <= ~turbo_phase;
    end else begin
      turbo_cnt <= turbo_cnt + 1'b1;
    end
  end

  assign eff_p1 = apply_turbo(sync_p1, sync_out[16], sync_out[17], turbo_phase);
  assign eff_p2 = apply_turbo(sync_p2, sync_out[18], sync_out[19], turbo_phase);
`else
  assign eff_p1 = sync_p1;
  assign eff_p2 = sync_p2;
`endif

  joypad_shifter u_pad1 (
    .clock      (clock),
    .reset      (reset),
    .strobe     (strobe),
    .nread      (naddr4016r),
    .buttons    (eff_p1),
    .serial_bit (bit_p1)
  );

  joypad_shifter u_pad2 (
    .clock      (clock),
    .reset      (reset),
    .strobe     (strobe),
    .nread      (naddr4017r),
    .buttons    (eff_p2),
    .serial_bit (bit_p2)
  );

  // Pad 1 has priority if the CPU ever drives both reads at once.
  always_comb begin
    joy_data = JOY_IDLE_DATA;
    if (!naddr4016r) begin
      joy_data = {7'b0, bit_p1};
    end else if (!naddr4017r) begin
      joy_data = {7'b0, bit_p2};
    end
  end

  assign joy_oe = ~naddr4016r | ~naddr4017r;

endmodule
